c_reg_piso_v5_0: RTL and testbench

Parallel-in/serial-out unload register for the baseblocks family: snapshots a C_WIDTH-bit register word on a load strobe and shifts it out one bit per accepted transfer over a valid/ready serial port. It is the read-out end of the parallel register path, draining captured register contents to serial consumers such as scan chains, debug taps and bit-serial datapaths. Single clock domain, synchronous clear.

---
 rtl/c_reg_piso_v5_0.sv | 138 +++++++++++++
 tb/tb_c_reg_piso_v5_0.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/c_reg_piso_v5_0.sv
// Parallel-in/serial-out unload register: snapshots a word on LOAD and drains it over a valid/ready serial port.
// Optional feature: define C_REG_PISO_PARITY_EN to append an even-parity bit after the data bits.
module c_reg_piso_v5_0 #(
  parameter int                   C_WIDTH     = 16,
  parameter logic [8*C_WIDTH-1:0] C_SINIT_VAL = "",
  parameter int                   C_MSB_FIRST = 1,
  parameter int                   C_HAS_CE    = 0
) (
  input  logic               clk_i,
  input  logic               sclr_i,
  input  logic               ce_i,
  input  logic [C_WIDTH-1:0] d_i,
  input  logic               load_i,
  output logic [C_WIDTH-1:0] q_o,
  output logic               busy_o,
  output logic               sdout_o,
  output logic               svalid_o,
  input  logic               sready_i,
  output logic               done_o
);

`ifdef C_REG_PISO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  localparam int             SRW      = C_WIDTH + PAR;
  localparam int             CW       = $clog2(C_WIDTH + 1);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(SRW - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // An all-NUL string (the "" default) means all zeros; otherwise every char must be '0' or '1'.
  function automatic logic sinit_ok(input logic [8*C_WIDTH-1:0] s);
    logic ok;
    ok = 1'b1;
    if (s != '0) begin
      for (int i = 0; i < C_WIDTH; i++) begin
        if ((s[8*i +: 8] != 8'h30) && (s[8*i +: 8] != 8'h31)) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  function automatic logic [C_WIDTH-1:0] sinit_bits(input logic [8*C_WIDTH-1:0] s);
    logic [C_WIDTH-1:0] v;
    for (int i = 0; i < C_WIDTH; i++) v[i] = (s[8*i +: 8] == 8'h31);
    return v;
  endfunction

  localparam logic [C_WIDTH-1:0] SINIT = sinit_bits(C_SINIT_VAL);

  if (!sinit_ok(C_SINIT_VAL)) begin : g_bad_sinit
    $fatal(1, "c_reg_piso_v5_0: C_SINIT_VAL must hold only '0'/'1' characters");
  end

  logic [0:0]         state_q, state_d;
  logic [SRW-1:0]     sr_q, sr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [C_WIDTH-1:0] q_q, q_d;
  logic               done_q, done_d;

  logic           ce_eff;
  logic           xfer;
  logic           final_xfer;
  logic [SRW-1:0] load_word;
  logic [SRW-1:0] sr_shift;

  assign ce_eff     = (C_HAS_CE != 0) ? ce_i : 1'b1;
  assign xfer       = ce_eff && (state_q == ST_SHIFT) && sready_i;
  assign final_xfer = xfer && (cnt_q == '0);

  // The parity bit sits at the far end of the word so it follows the last data bit out.
`ifdef C_REG_PISO_PARITY_EN
  assign load_word = (C_MSB_FIRST != 0) ? {d_i, ^d_i} : {^d_i, d_i};
`else
  assign load_word = d_i;
`endif

  assign sr_shift = (C_MSB_FIRST != 0) ? {sr_q[SRW-2:0], 1'b0} : {1'b0, sr_q[SRW-1:1]};

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    done_d  = final_xfer;
    if (ce_eff) begin
      if (state_q == ST_IDLE) begin
        if (load_i) begin
          q_d     = d_i;
          sr_d    = load_word;
          cnt_d   = CNT_LOAD;
          state_d = ST_SHIFT;
        end
      end else if (xfer) begin
        // Shifting on the final bit too leaves SR empty, so SDOUT reads 0 once idle.
        sr_d = sr_shift;
        if (cnt_q == '0) begin
          if (load_i) begin
            q_d   = d_i;
            sr_d  = load_word;
            cnt_d = CNT_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (sclr_i) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      q_q     <= SINIT;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      done_q  <= done_d;
    end
  end

  assign q_o      = q_q;
  assign busy_o   = (state_q == ST_SHIFT);
  assign svalid_o = (state_q == ST_SHIFT);
  assign sdout_o  = (C_MSB_FIRST != 0) ? sr_q[SRW-1] : sr_q[0];
  assign done_o   = done_q;

endmodule

// File: tb/tb_c_reg_piso_v5_0.sv
// Self-checking bench for c_reg_piso_v5_0: an MSB-first and an LSB-first instance share stimulus
// and are compared against a bit-list reference model (honours C_REG_PISO_PARITY_EN).
module tb_c_reg_piso_v5_0;

`ifdef C_REG_PISO_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clock;
  logic       sclr, ce, load, sready;
  logic [7:0] d;

  logic [7:0] qOut      [2];
  logic       busyOut   [2];
  logic       sdoutOut  [2];
  logic       svalidOut [2];
  logic       doneOut   [2];

  int total = 0;
  int bad   = 0;

  logic [NB-1:0] pendBits  [2];
  int            pendLen   [2];
  logic [7:0]    qModel    [2];
  logic          doneModel [2];

  c_reg_piso_v5_0 #(.C_WIDTH(8), .C_SINIT_VAL("00001111"), .C_MSB_FIRST(1), .C_HAS_CE(1)) dutMsb (
    .clk_i(clock), .sclr_i(sclr), .ce_i(ce), .d_i(d), .load_i(load),
    .q_o(qOut[0]), .busy_o(busyOut[0]), .sdout_o(sdoutOut[0]),
    .svalid_o(svalidOut[0]), .sready_i(sready), .done_o(doneOut[0])
  );

  c_reg_piso_v5_0 #(.C_WIDTH(8), .C_SINIT_VAL("00001111"), .C_MSB_FIRST(0), .C_HAS_CE(1)) dutLsb (
    .clk_i(clock), .sclr_i(sclr), .ce_i(ce), .d_i(d), .load_i(load),
    .q_o(qOut[1]), .busy_o(busyOut[1]), .sdout_o(sdoutOut[1]),
    .svalid_o(svalidOut[1]), .sready_i(sready), .done_o(doneOut[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // List of bits in the order they must appear on SDOUT; element 0 goes first.
  function automatic logic [NB-1:0] bitsOf(logic [7:0] dv, bit msb);
    logic [NB-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i] = msb ? dv[7-i] : dv[i];
    if (NB > 8) r[NB-1] = ^dv;
    return r;
  endfunction

  // Advance the reference model across one clock edge using the inputs currently applied.
  task automatic modelStep();
    for (int k = 0; k < 2; k++) begin
      bit xfer, last, accept;
      xfer   = ce && (pendLen[k] > 0) && sready;
      last   = xfer && (pendLen[k] == 1);
      accept = ce && load && ((pendLen[k] == 0) || last);
      if (sclr) begin
        pendLen[k]   = 0;
        pendBits[k]  = '0;
        qModel[k]    = 8'h0F;
        doneModel[k] = 1'b0;
      end else if (!ce) begin
        doneModel[k] = 1'b0;
      end else begin
        doneModel[k] = last;
        if (xfer) begin
          pendBits[k] = pendBits[k] >> 1;
          pendLen[k]  = pendLen[k] - 1;
        end
        if (accept) begin
          pendBits[k] = bitsOf(d, k == 0);
          pendLen[k]  = NB;
          qModel[k]   = d;
        end
      end
    end
  endtask

  task automatic checkOutput(string name, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkModel();
    for (int k = 0; k < 2; k++) begin
      string tag;
      tag = (k == 0) ? "msb" : "lsb";
      checkOutput({tag, ".sdout"},  {7'd0, sdoutOut[k]},
                  {7'd0, (pendLen[k] > 0) ? pendBits[k][0] : 1'b0});
      checkOutput({tag, ".svalid"}, {7'd0, svalidOut[k]}, {7'd0, pendLen[k] > 0});
      checkOutput({tag, ".busy"},   {7'd0, busyOut[k]},   {7'd0, pendLen[k] > 0});
      checkOutput({tag, ".done"},   {7'd0, doneOut[k]},   {7'd0, doneModel[k]});
      checkOutput({tag, ".q"},      qOut[k],              qModel[k]);
    end
  endtask

  task automatic applyStimulus(logic s, logic c, logic l, logic [7:0] dv, logic r);
    sclr = s; ce = c; load = l; d = dv; sready = r;
    modelStep();
    @(posedge clock);
    #1;
    checkModel();
  endtask

  typedef struct packed {
    logic       sclr, ce, load;
    logic [7:0] d;
    logic       sready;
    logic       expSdout, expSvalid, expBusy, expDone;
    logic [7:0] expQ;
  } vecT;

  vecT vecs [11];

  initial begin
    int doneAt, doneCount, firstDone, secondDone, busyDrop, frozenBad;
    logic held;

    sclr = 1'b0; ce = 1'b1; load = 1'b0; d = 8'h00; sready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      pendLen[k] = 0; pendBits[k] = '0; qModel[k] = 8'h0F; doneModel[k] = 1'b0;
    end
    @(negedge clock);

    // MSB-first drain of 8'hA5 at full rate, expectations written out by hand.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0F};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};

`ifndef C_REG_PISO_PARITY_EN
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].sclr, vecs[i].ce, vecs[i].load, vecs[i].d, vecs[i].sready);
      checkOutput($sformatf("vec%0d.sdout", i),  {7'd0, sdoutOut[0]},  {7'd0, vecs[i].expSdout});
      checkOutput($sformatf("vec%0d.svalid", i), {7'd0, svalidOut[0]}, {7'd0, vecs[i].expSvalid});
      checkOutput($sformatf("vec%0d.busy", i),   {7'd0, busyOut[0]},   {7'd0, vecs[i].expBusy});
      checkOutput($sformatf("vec%0d.done", i),   {7'd0, doneOut[0]},   {7'd0, vecs[i].expDone});
      checkOutput($sformatf("vec%0d.q", i),      qOut[0],              vecs[i].expQ);
    end
`else
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    for (int w = 0; w < 2; w++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, (w == 0) ? 8'h07 : 8'h03, 1'b1);
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
      checkOutput($sformatf("parity%0d.bit", w), {7'd0, sdoutOut[0]}, {7'd0, w == 0});
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
      checkOutput($sformatf("parity%0d.done", w), {7'd0, doneOut[0]}, 8'd1);
    end
`endif

    // 8'h01 with SREADY alternating 0/1: every bit held through a stall cycle.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h01, 1'b0);
    doneAt = -1;
    for (int i = 1; i <= 4 * NB && doneAt < 0; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, (i % 2) == 0);
      if (doneOut[1] === 1'b1) doneAt = i;
    end
    checkOutput("stall.cyclesToDone", doneAt[7:0], 8'(2 * NB));

    // Back-to-back words: 8'hFF then 8'h00 captured on the final transfer.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hFF, 1'b1);
    doneCount = 0; firstDone = -1; secondDone = -1; busyDrop = 0;
    for (int j = 1; j <= 2 * NB + 1; j++) begin
      applyStimulus(1'b0, 1'b1, j == NB, 8'h00, 1'b1);
      if (j < 2 * NB && busyOut[0] !== 1'b1) busyDrop++;
      if (doneOut[0] === 1'b1) begin
        doneCount++;
        if (firstDone < 0) firstDone = j; else secondDone = j;
      end
    end
    checkOutput("b2b.busyDrops", busyDrop[7:0], 8'd0);
    checkOutput("b2b.doneCount", doneCount[7:0], 8'd2);
    checkOutput("b2b.firstDone", firstDone[7:0], 8'(NB));
    checkOutput("b2b.doneGap", 8'(secondDone - firstDone), 8'(NB));

    // SCLR after three bits of 8'hC3 aborts the word with no DONE.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hC3, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    checkOutput("sclr.svalid", {7'd0, svalidOut[0]}, 8'd0);
    checkOutput("sclr.busy",   {7'd0, busyOut[0]},   8'd0);
    checkOutput("sclr.q",      qOut[0],              8'h0F);
    doneCount = 0;
    for (int i = 0; i < NB; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
      if (doneOut[0] === 1'b1) doneCount++;
    end
    checkOutput("sclr.noDone", doneCount[7:0], 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h3C, 1'b1);
    for (int i = 0; i < NB + 1; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);

    // CE low for four cycles mid-word with SREADY and LOAD asserted.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h5A, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    held = sdoutOut[0];
    frozenBad = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF, 1'b1);
      if (sdoutOut[0] !== held || busyOut[0] !== 1'b1) frozenBad++;
    end
    checkOutput("ce.frozen", frozenBad[7:0], 8'd0);
    checkOutput("ce.qKept", qOut[0], 8'h5A);
    for (int i = 0; i < NB; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);

    // Randomized traffic checked cycle by cycle against the model.
    for (int i = 0; i < 800; i++) begin
      applyStimulus($urandom_range(0, 59) == 0, $urandom_range(0, 7) != 0,
                    $urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 2) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
